ram4k_ctrl: RTL and testbench
=============================

# ram4k_ctrl

Two-port round-robin access controller and clear sequencer for the 4096×16 RAM4K storage array. It sits between two requesters (port 0 and port 1, e.g. CPU data bus and a DMA/screen fetcher) and one RAM4K instance. It grants at most one access per cycle and returns read data one cycle after the grant. It can also zero-fill, or pattern-fill, the whole array on command.

## Interface
Parameters:
- CLEAR_VALUE, 16'h0000, word written to every address during a clear sweep

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid[1:0]  in  2  per-port request valid
- req_we[1:0]  in  2  per-port write enable (1 = write, 0 = read)
- req_addr0, req_addr1  in  12  per-port word address
- req_wdata0, req_wdata1  in  16  per-port write data
- req_ready[1:0]  out  2  per-port grant; handshake completes when valid & ready
- rsp_valid[1:0]  out  2  per-port read-data valid, one-cycle pulse
- rsp_rdata  out  16  read data; shared by both ports, qualified by rsp_valid
- clear_start  in  1  single-cycle pulse that starts a full-array fill with CLEAR_VALUE
- busy  out  1  high while a clear sweep is running
- clear_done  out  1  single-cycle pulse after the last clear write
- mem_address  out  12  to RAM4K address
- mem_in  out  16  to RAM4K in
- mem_load  out  1  to RAM4K load
- mem_out  in  16  from RAM4K out (combinational read of mem_address)

## Operation
- FSM states: IDLE (serve requests) and CLEAR (sweep).
- IDLE arbitration:
  - Only one port valid: that port is granted.
  - Both ports valid: the port not granted last is granted. last_grant resets to 1, so port 0 wins the first contest.
  - last_grant updates only on a completed handshake.
- Granted port drives the RAM:
  - mem_address = its addr, mem_in = its wdata, mem_load = its we.
  - req_ready is high for that port only; it is combinational from req_valid and state.
- Write commits at the granting clock edge.
- Read: mem_out is registered into rsp_rdata at the granting edge, and rsp_valid[port] pulses the next cycle.
- No grant: mem_load = 0, mem_address holds its previous value, rsp_valid = 0, rsp_rdata holds.
- clear_start in IDLE:
  - Transition to CLEAR at the next edge, with counter = 0. Any handshake completing in that same cycle still completes normally.
  - CLEAR takes priority over requests arriving in the start cycle only after the transition.
- CLEAR sweep:
  - req_ready = 0 for both ports.
  - mem_address = counter, mem_in = CLEAR_VALUE, mem_load = 1.
  - The counter increments each cycle, giving 4096 writes.
  - After the write at address 4095: clear_done pulses for one cycle, counter wraps to 0, state returns to IDLE.
- clear_start while in CLEAR is ignored and does not restart the sweep.
- Reset asserted mid-sweep aborts immediately. Array contents are then partially cleared; the controller does not track this.
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, busy 0, clear_done 0, mem_load 0, mem_address 0, mem_in 0, state IDLE, counter 0, last_grant 1.

## Timing
- Grant: same cycle as req_valid when in IDLE. Zero-cycle request-to-ready.
- Read latency: rsp_valid exactly 1 cycle after the handshake cycle.
- Back-to-back: one handshake per cycle sustained.
  - Alternating grants when both ports hold valid.
  - Full rate for a single active port.
- Clear: busy rises the cycle after clear_start. The sweep is 4096 cycles. clear_done and busy fall together with the return to IDLE. First grant is possible in the cycle after clear_done.
- Requesters must hold req_valid, addr, we and wdata stable until ready.

## Structure
- Shared package ram4k_ctrl_pkg holds:
  - ADDR_W = 12, DATA_W = 16, DEPTH = 4096
  - state enum {ST_IDLE, ST_CLEAR}
- Sub-module rr_arb2: a two-requester round-robin picker.
  - Inputs: req[1:0], last_grant, enable.
  - Output: one-hot grant[1:0].
  - Purely combinational. last_grant is held in ram4k_ctrl.
- The RAM4K instance is external to this block and is connected by the integrating top.

## Test plan
- Port 0 writes 16'hBEEF to 12'h123, then port 0 reads 12'h123 -> ready same cycle; rsp_valid[0] one cycle after the read; rsp_rdata = 16'hBEEF.
- Both ports hold valid reads of 12'h001 and 12'h002 for 4 cycles after reset -> grants 0,1,0,1; rsp_valid pulses alternate and match the stored data.
- Port 1 writes 16'h0042 to 12'hFFF, then clear_start with CLEAR_VALUE = 16'hA5A5 -> busy for exactly 4096 cycles and clear_done is a single pulse; a subsequent read of 12'hFFF and 12'h000 returns 16'hA5A5.
- Port 0 valid throughout a clear, plus clear_start re-pulsed at sweep cycle 100 -> req_ready[0] stays 0 until after clear_done; the sweep length is still 4096; port 0 is granted the cycle after clear_done.
- rst_n asserted at sweep cycle 2000 -> all outputs at reset values asynchronously; after release the controller is IDLE and port 0 wins the first contest.
- Read and write on the same port back-to-back to 12'h7FF (write 16'h1234, then read) -> the read returns 16'h1234 with no stall.

Source files
------------

// File: rtl/ram4k_ctrl_pkg.sv
// ram4k_ctrl_pkg
//   Shared sizes and types for the RAM4K access controller.
//   ADDR_W / DATA_W / DEPTH describe the 4096 x 16 storage array.
//   state_t is the controller mode: serving requests or sweeping a clear.
package ram4k_ctrl_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4096;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-requester round-robin picker, purely combinational.
//   Ports:
//     req[1:0]    in   request lines, bit n = port n
//     last_grant  in   port that completed the most recent handshake
//     enable      in   when low no grant is issued
//     grant[1:0]  out  one-hot grant (or zero)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // Contention: the port that did not win last time goes now.
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/ram4k_ctrl.sv
// ram4k_ctrl
//   Round-robin access controller and clear sequencer in front of one
//   RAM4K (4096 x 16) array. At most one access per cycle; read data is
//   returned one cycle after the grant. A clear sweep writes CLEAR_VALUE to
//   every address, one address per cycle.
//   Ports:
//     clk, rst_n                   clock, asynchronous active-low reset
//     req_valid/req_we[1:0]        per-port request valid / write enable
//     req_addr0/1, req_wdata0/1    per-port address and write data
//     req_ready[1:0]               per-port grant (combinational)
//     rsp_valid[1:0], rsp_rdata    read response, one cycle after grant
//     clear_start, busy,clear_done clear sweep control and status
//     mem_address/in/load, mem_out connection to the RAM4K instance
module ram4k_ctrl
    import ram4k_ctrl_pkg::*;
#(
    parameter logic [DATA_W-1:0] CLEAR_VALUE = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              clear_start,
    output logic              busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_counter;
    logic [ADDR_W-1:0] r_addr_hold;
    logic              r_last_grant;
    logic [1:0]        r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [1:0]        w_grant;
    logic [1:0]        w_rd_grant;
    logic              w_sweep_last;
    logic              w_arb_en;

    // Gating with rst_n keeps req_ready (and hence mem_load) at zero while
    // reset is held, even if requesters keep valid asserted.
    assign w_arb_en = (r_state == ST_IDLE) && rst_n;

    rr_arb2 u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .enable     (w_arb_en),
        .grant      (w_grant)
    );

    assign w_rd_grant   = w_grant & ~req_we;
    assign w_sweep_last = (r_state == ST_CLEAR) && (r_counter == ADDR_W'(DEPTH - 1));

    assign req_ready  = w_grant;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign busy       = (r_state == ST_CLEAR);
    assign clear_done = w_sweep_last;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (clear_start)  w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (w_sweep_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // RAM drive. With no grant the address parks on its last value so the
    // array sees a stable address between accesses.
    always_comb begin
        mem_address = r_addr_hold;
        mem_in      = '0;
        mem_load    = 1'b0;
        if (r_state == ST_CLEAR) begin
            mem_address = r_counter;
            mem_in      = CLEAR_VALUE;
            mem_load    = 1'b1;
        end else if (w_grant[0]) begin
            mem_address = req_addr0;
            mem_in      = req_wdata0;
            mem_load    = req_we[0];
        end else if (w_grant[1]) begin
            mem_address = req_addr1;
            mem_in      = req_wdata1;
            mem_load    = req_we[1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_counter    <= '0;
            r_addr_hold  <= '0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 2'b00;
            r_rsp_rdata  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            // Counter runs only in CLEAR; the 12-bit wrap after 4095
            // returns it to 0 together with the exit to IDLE.
            r_counter   <= (r_state == ST_CLEAR) ? r_counter + ADDR_W'(1) : '0;
            r_addr_hold <= mem_address;
            if (|w_grant) begin
                r_last_grant <= w_grant[1];
            end
            r_rsp_valid <= w_rd_grant;
            if (|w_rd_grant) begin
                r_rsp_rdata <= mem_out;
            end
        end
    end

endmodule

// File: tb/tb_ram4k_ctrl.sv
// tb_ram4k_ctrl
//   Directed bench for ram4k_ctrl with a behavioural RAM4K attached.
module tb_ram4k_ctrl;
    import ram4k_ctrl_pkg::*;

    localparam logic [15:0] CLR = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [11:0] req_addr0;
    logic [11:0] req_addr1;
    logic [15:0] req_wdata0;
    logic [15:0] req_wdata1;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic        clear_start;
    logic        busy;
    logic        clear_done;
    logic [11:0] mem_address;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out;

    int n_vec;
    int n_err;

    always #5 clk = ~clk;

    ram4k_ctrl #(.CLEAR_VALUE(CLR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr0   (req_addr0),
        .req_addr1   (req_addr1),
        .req_wdata0  (req_wdata0),
        .req_wdata1  (req_wdata1),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .clear_start (clear_start),
        .busy        (busy),
        .clear_done  (clear_done),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_load    (mem_load),
        .mem_out     (mem_out)
    );

    // Behavioural RAM4K: combinational read, write on the rising edge.
    logic [15:0] ram [0:4095];
    assign mem_out = ram[mem_address];
    always @(posedge clk) begin
        if (mem_load) ram[mem_address] <= mem_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = 2'b00;
        req_we      = 2'b00;
        clear_start = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_port(input int p, input logic we, input logic [11:0] a, input logic [15:0] d);
        if (p == 0) begin
            req_valid = 2'b01; req_we = {1'b0, we}; req_addr0 = a; req_wdata0 = d;
        end else begin
            req_valid = 2'b10; req_we = {we, 1'b0}; req_addr1 = a; req_wdata1 = d;
        end
    endtask

    task automatic wr(input int p, input logic [11:0] a, input logic [15:0] d);
        set_port(p, 1'b1, a, d);
        #1;
        check("wr_ready", req_ready, (p == 0) ? 2'b01 : 2'b10);
        check("wr_load", mem_load, 1'b1);
        tick();
        check("wr_no_rsp", rsp_valid, 2'b00);
        idle_inputs();
    endtask

    task automatic rd(input int p, input logic [11:0] a, input logic [15:0] exp);
        set_port(p, 1'b0, a, 16'h0000);
        #1;
        check("rd_ready", req_ready, (p == 0) ? 2'b01 : 2'b10);
        tick();
        check("rd_rsp_valid", rsp_valid, (p == 0) ? 2'b01 : 2'b10);
        check("rd_rdata", rsp_rdata, exp);
        idle_inputs();
    endtask

    // Runs until busy drops (bounded). restart_at >= 0 re-pulses
    // clear_start during that sweep cycle.
    task automatic sweep(input int restart_at, output int n_busy, output int n_done,
                         output int done_idx, output int n_ready_bad);
        n_busy = 0; n_done = 0; done_idx = -1; n_ready_bad = 0;
        while (busy && n_busy < 5000) begin
            if (req_ready != 2'b00) n_ready_bad++;
            if (clear_done) begin
                n_done++;
                done_idx = n_busy;
            end
            clear_start = (n_busy == restart_at);
            n_busy++;
            tick();
        end
        clear_start = 1'b0;
    endtask

    int nb, nd, di, bad;

    initial begin
        n_vec = 0; n_err = 0;
        idle_inputs();
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values, with requests present to show they are not granted.
        req_valid = 2'b11; req_we = 2'b11; req_addr0 = 12'h055; req_wdata0 = 16'h7777;
        #1;
        check("rst_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rdata", rsp_rdata, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", clear_done, 1'b0);
        check("rst_load", mem_load, 1'b0);
        check("rst_addr", mem_address, 12'h000);
        check("rst_in", mem_in, 16'h0000);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Preload two words, then reset so last_grant is back at its reset value.
        wr(0, 12'h001, 16'h1111);
        wr(1, 12'h002, 16'h2222);
        do_reset();

        // Both ports hold valid reads: grants 0,1,0,1.
        req_valid = 2'b11; req_we = 2'b00; req_addr0 = 12'h001; req_addr1 = 12'h002;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_addr", mem_address, (i % 2 == 0) ? 12'h001 : 12'h002);
            tick();
            check("rr_rsp_valid", rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_rdata", rsp_rdata, (i % 2 == 0) ? 16'h1111 : 16'h2222);
        end
        idle_inputs();
        tick();
        check("idle_rsp_valid", rsp_valid, 2'b00);
        check("idle_rdata_hold", rsp_rdata, 16'h2222);
        check("idle_addr_hold", mem_address, 12'h002);
        check("idle_load", mem_load, 1'b0);

        // Port 0 write then read.
        wr(0, 12'h123, 16'hBEEF);
        rd(0, 12'h123, 16'hBEEF);

        // Same-port write then read back-to-back, no stall.
        set_port(0, 1'b1, 12'h7FF, 16'h1234);
        #1;
        check("b2b_wr_ready", req_ready, 2'b01);
        tick();
        req_we = 2'b00;
        #1;
        check("b2b_rd_ready", req_ready, 2'b01);
        tick();
        check("b2b_rsp_valid", rsp_valid, 2'b01);
        check("b2b_rdata", rsp_rdata, 16'h1234);
        idle_inputs();

        // Port 1 write to the top address, then a full clear.
        wr(1, 12'hFFF, 16'h0042);
        rd(1, 12'hFFF, 16'h0042);
        clear_start = 1'b1;
        #1;
        check("clr_busy_start_cycle", busy, 1'b0);
        tick();
        clear_start = 1'b0;
        #1;
        check("clr_busy_rise", busy, 1'b1);
        check("clr_first_addr", mem_address, 12'h000);
        check("clr_in", mem_in, CLR);
        check("clr_load", mem_load, 1'b1);
        sweep(-1, nb, nd, di, bad);
        check("clr_len", nb, 4096);
        check("clr_done_count", nd, 1);
        check("clr_done_last_cycle", di, 4095);
        check("clr_busy_fall", busy, 1'b0);
        check("clr_done_fall", clear_done, 1'b0);
        rd(1, 12'hFFF, CLR);
        rd(0, 12'h000, CLR);

        // Port 0 held valid through a clear, with a stray restart at cycle 100.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        set_port(0, 1'b0, 12'h010, 16'h0000);
        sweep(100, nb, nd, di, bad);
        check("hold_len", nb, 4096);
        check("hold_ready_blocked", bad, 0);
        check("hold_done_count", nd, 1);
        #1;
        check("hold_grant_after_done", req_ready, 2'b01);
        tick();
        check("hold_rsp_valid", rsp_valid, 2'b01);
        check("hold_rdata", rsp_rdata, CLR);
        idle_inputs();

        // Reset in the middle of a sweep.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (2000) tick();
        check("mid_busy", busy, 1'b1);
        check("mid_addr", mem_address, 12'd2000);
        req_valid = 2'b11; req_we = 2'b00; req_addr0 = 12'h123; req_addr1 = 12'h7FF;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", req_ready, 2'b00);
        check("arst_busy", busy, 1'b0);
        check("arst_load", mem_load, 1'b0);
        check("arst_addr", mem_address, 12'h000);
        check("arst_in", mem_in, 16'h0000);
        check("arst_rsp_valid", rsp_valid, 2'b00);
        check("arst_rdata", rsp_rdata, 16'h0000);
        check("arst_done", clear_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_p0_wins", req_ready, 2'b01);
        check("post_rst_idle", busy, 1'b0);
        tick();
        check("post_rst_rsp", rsp_valid, 2'b01);
        check("post_rst_p1_next", req_ready, 2'b10);
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
